// File: rtl/sfp_reset_sequencer.sv
// SFP transceiver reset sequencer: PLL lock -> PHY reset release -> MAC reset release -> RUN.
// Optional PHY-ready watchdog with FAULT back-off is enabled by defining SFP_RST_WATCHDOG_EN.
module sfp_reset_sequencer #(
    parameter int unsigned SYNC_DEPTH     = 2,
    parameter int unsigned HOLD_CYCLES    = 256,
    parameter int unsigned TIMEOUT_CYCLES = 65536
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       phy_done,
    input  logic       sw_reset,
    output logic       phy_rst,
    output logic       mac_rst,
    output logic       link_ready,
    output logic [2:0] state,
    output logic [7:0] retry_cnt
);

    localparam logic [2:0] StWaitLock = 3'd0;
    localparam logic [2:0] StHold     = 3'd1;
    localparam logic [2:0] StPhyWait  = 3'd2;
    localparam logic [2:0] StMacHold  = 3'd3;
    localparam logic [2:0] StRun      = 3'd4;
    localparam logic [2:0] StFault    = 3'd5;

    localparam int unsigned CntMax = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES
                                                                     : TIMEOUT_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_CYCLES - 1);
    localparam logic [CntW-1:0] CntSat   = CntW'(CntMax);
`ifdef SFP_RST_WATCHDOG_EN
    localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);
`endif

    (* ASYNC_REG = "TRUE" *) logic [SYNC_DEPTH-1:0] lock_sync_q;
    (* ASYNC_REG = "TRUE" *) logic [SYNC_DEPTH-1:0] done_sync_q;
    logic lock_s;
    logic done_s;

    logic [2:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            phy_rst_q, phy_rst_d;
    logic            mac_rst_q, mac_rst_d;
    logic            link_q, link_d;
    logic            counting;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_sync_q <= '0;
            done_sync_q <= '0;
        end else begin
            lock_sync_q <= {lock_sync_q[SYNC_DEPTH-2:0], pll_locked};
            done_sync_q <= {done_sync_q[SYNC_DEPTH-2:0], phy_done};
        end
    end

    assign lock_s = lock_sync_q[SYNC_DEPTH-1];
    assign done_s = done_sync_q[SYNC_DEPTH-1];

    // sw_reset dominates; loss of lock beats expiry or done_s in every timed state.
    always_comb begin
        state_d = state_q;
        if (sw_reset) begin
            state_d = StWaitLock;
        end else begin
            case (state_q)
                StWaitLock: begin
                    if (lock_s) state_d = StHold;
                end
                StHold: begin
                    if (!lock_s)                state_d = StWaitLock;
                    else if (cnt_q == HoldLast) state_d = StPhyWait;
                end
                StPhyWait: begin
                    if (!lock_s)     state_d = StWaitLock;
                    else if (done_s) state_d = StMacHold;
`ifdef SFP_RST_WATCHDOG_EN
                    else if (cnt_q == TimeoutLast) state_d = StFault;
`endif
                end
                StMacHold: begin
                    if (!lock_s)                state_d = StWaitLock;
                    else if (cnt_q == HoldLast) state_d = StRun;
                end
                StRun: begin
                    if (!lock_s || !done_s) state_d = StWaitLock;
                end
                StFault: begin
`ifdef SFP_RST_WATCHDOG_EN
                    if (cnt_q == HoldLast) state_d = StWaitLock;
`else
                    state_d = StWaitLock;
`endif
                end
                default: state_d = StWaitLock;
            endcase
        end
    end

    assign counting = (state_q == StHold) || (state_q == StPhyWait) ||
                      (state_q == StMacHold) || (state_q == StFault);

    // Saturating dwell counter, restarted on every state change.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (counting && (cnt_q != CntSat)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        phy_rst_d = !((state_d == StPhyWait) || (state_d == StMacHold) || (state_d == StRun));
        mac_rst_d = (state_d != StRun);
        link_d    = (state_d == StRun);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StWaitLock;
            cnt_q     <= '0;
            phy_rst_q <= 1'b1;
            mac_rst_q <= 1'b1;
            link_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            phy_rst_q <= phy_rst_d;
            mac_rst_q <= mac_rst_d;
            link_q    <= link_d;
        end
    end

`ifdef SFP_RST_WATCHDOG_EN
    logic [7:0] retry_q, retry_d;

    always_comb begin
        retry_d = retry_q;
        if ((state_q == StPhyWait) && (state_d == StFault) && (retry_q != 8'hFF)) begin
            retry_d = retry_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retry_q <= 8'd0;
        end else begin
            retry_q <= retry_d;
        end
    end

    assign retry_cnt = retry_q;
`else
    assign retry_cnt = 8'd0;
`endif

    assign state      = state_q;
    assign phy_rst    = phy_rst_q;
    assign mac_rst    = mac_rst_q;
    assign link_ready = link_q;

endmodule
